framebuffer_writer: RTL and testbench
=====================================

// Module: framebuffer_writer
// PURPOSE
//  Pixel-stream sink for the rasterizer output: takes (hcount, vcount, valid) pixels, clips to the frame,
//  computes the linear framebuffer address and drives a BRAM write port. Also performs whole-frame clears
//  on request. Sits between rasterizer and the framebuffer BRAM read by the video/display path.
// PARAMETERS
//  WIDTH      320                 frame width in pixels
//  HEIGHT     180                 frame height in pixels
//  COLOR_W    8                   pixel colour width
//  ADDR_W     $clog2(WIDTH*HEIGHT) linear address width (16 at defaults)
// PORTS
//  clk_in              in   1        single clock
//  rst_in              in   1        synchronous, active-low reset (0 = reset)
//  hcount_in           in   11       pixel x
//  vcount_in           in   10       pixel y
//  pixel_valid_in      in   1        pixel present this cycle
//  color_in            in   COLOR_W  pixel colour
//  ready_out           out  1        1 = pixels accepted this cycle (0 during DRAIN/CLEAR)
//  clear_in            in   1        1-cycle pulse: fill frame with clear_color_in
//  clear_color_in      in   COLOR_W  fill colour, sampled with clear_in
//  busy_out            out  1        1 while in DRAIN or CLEAR
//  bram_addr_out       out  ADDR_W(+1) write address (+1 bank MSB with DOUBLE_BUFFER_EN)
//  bram_data_out       out  COLOR_W  write data
//  bram_we_out         out  1        write enable
//  dropped_count_out   out  16       pixels lost (clipped or offered while ready_out=0), saturating
//  bank_sel_out        out  1        display bank (see CONFIGURATION)
//  swap_in             in   1        request bank swap (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state DRAW, pipeline empty, all outputs 0 except ready_out=1; dropped_count_out=0.
//  - Accept: pixel taken when pixel_valid_in && ready_out. No backpressure beyond ready_out; offered
//    pixel with ready_out=0 is dropped and counted.
//  - Clip: hcount_in>=WIDTH or vcount_in>=HEIGHT -> no write, dropped_count_out +1.
//  - Pipeline, 2 stages: S1 registers vcount*WIDTH (ADDR_W bits, no overflow after clip), hcount, colour;
//    S2 registers addr = S1 + hcount, data, we=1. Write appears on BRAM port 2 cycles after acceptance.
//    Back-to-back pixels sustain 1 write/cycle; bram_we_out is 0 on cycles with no write.
//  - FSM DRAW -> (clear_in) DRAIN -> (pipeline empty) CLEAR -> (addr == WIDTH*HEIGHT-1 written) DRAW.
//    DRAIN lasts exactly until both stages empty (<=2 cycles; 0 cycles if already empty -> direct to CLEAR).
//    CLEAR writes clear colour to addr 0..WIDTH*HEIGHT-1, one per cycle, we=1 each cycle.
//  - clear_in while DRAIN/CLEAR: ignored (no restart). clear_in same cycle as an accepted pixel: pixel is
//    accepted and written before the clear sweep begins.
//  - Reset mid-CLEAR/DRAIN: aborts immediately, pipeline flushed, no further writes.
//  - dropped_count_out saturates at 16'hFFFF; at most +1 per cycle.
// CONFIGURATION
//  DOUBLE_BUFFER_EN defined: two banks; write bank = ~bank_sel_out, bram_addr_out MSB = write bank.
//    swap_in toggles bank_sel_out once pipeline is empty and state is DRAW (pending swap held, pixels
//    stalled via ready_out=0 until done). swap_in and clear_in same cycle: swap first, then clear the
//    new write bank.
//  Not defined: single bank, bram_addr_out is ADDR_W bits, bank_sel_out tied 0, swap_in ignored.
// STRUCTURE
//  - Shared package rendering_pkg: WIDTH/HEIGHT defaults, COLOR_W, fb_state_t enum {DRAW,DRAIN,CLEAR},
//    pixel_t struct {hcount, vcount, color}.
//  - Sub-module fb_addr_gen: clip check + 2-stage address pipeline (valid, addr, data out).
// TESTING (WIDTH=320, HEIGHT=180, COLOR_W=8)
//  - Pixel (10,2,8'h5A) valid -> 2 cycles later we=1, addr=650, data=8'h5A; next cycle we=0.
//  - Pixels (319,179) then (320,0) back-to-back -> one write addr=57599; dropped_count_out=1.
//  - clear_in with color 8'h00 while 2 pixels in flight -> both pixels written, then 57600 consecutive
//    writes addr 0..57599 data 8'h00; busy_out=1 throughout, ready_out=1 the cycle after the last.
//  - pixel_valid_in held high for 10 cycles during CLEAR -> no pixel writes, dropped_count_out +10.
//  - Reset (rst_in=0) at clear addr 1000 -> next cycle we=0, busy_out=0, ready_out=1, counter 0.
//  - DOUBLE_BUFFER_EN: swap_in -> bank_sel_out 0->1; pixel (0,0) writes addr MSB=0; swap+clear
//    together -> bank_sel_out=0, clear sweep writes with MSB=1.

Source files
------------

// File: rtl/rendering_pkg.sv
// Shared types for the rendering path.
//   DefWidth/DefHeight/DefColorW : default frame geometry and pixel colour width
//   fb_state_t                   : framebuffer writer states
//   pixel_t                      : one rasterizer pixel {hcount, vcount, color}
//   pix_in_frame()               : clip test against a frame size
package rendering_pkg;

  localparam int unsigned DefWidth  = 320;
  localparam int unsigned DefHeight = 180;
  localparam int unsigned DefColorW = 8;

  typedef enum logic [1:0] {
    DRAW,
    DRAIN,
    CLEAR
  } fb_state_t;

  typedef struct packed {
    logic [10:0]          hcount;
    logic [9:0]           vcount;
    logic [DefColorW-1:0] color;
  } pixel_t;

  function automatic logic pix_in_frame(input pixel_t p, input int unsigned w,
                                        input int unsigned h);
    return (32'(p.hcount) < w) && (32'(p.vcount) < h);
  endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Clip check plus 2-stage linear address pipeline.
//   clk_in, rst_in : clock, synchronous active-low reset
//   take_in        : pixel accepted this cycle
//   pixel_in       : accepted pixel
//   clipped        : pixel lies outside the frame (combinational)
//   s1_valid       : stage 1 holds a pixel
//   wr_valid       : stage 2 holds a write (addr/data valid)
//   wr_addr        : linear address vcount*WIDTH + hcount
//   wr_data        : pixel colour
module fb_addr_gen
  import rendering_pkg::*;
#(
  parameter int unsigned WIDTH  = DefWidth,
  parameter int unsigned HEIGHT = DefHeight,
  parameter int unsigned ADDR_W = $clog2(WIDTH * HEIGHT)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 take_in,
  input  pixel_t               pixel_in,
  output logic                 clipped,
  output logic                 s1_valid,
  output logic                 wr_valid,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [DefColorW-1:0] wr_data
);

  localparam logic [ADDR_W-1:0] WidthA = ADDR_W'(WIDTH);

  logic                 s1_valid_q;
  logic [ADDR_W-1:0]    s1_row_q, s1_col_q;
  logic [DefColorW-1:0] s1_color_q;
  logic                 s2_valid_q;
  logic [ADDR_W-1:0]    s2_addr_q;
  logic [DefColorW-1:0] s2_color_q;

  assign clipped = !pix_in_frame(pixel_in, WIDTH, HEIGHT);

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      s1_valid_q <= 1'b0;
      s1_row_q   <= '0;
      s1_col_q   <= '0;
      s1_color_q <= '0;
      s2_valid_q <= 1'b0;
      s2_addr_q  <= '0;
      s2_color_q <= '0;
    end else begin
      s1_valid_q <= take_in && !clipped;
      // Product cannot overflow once vcount has passed the clip check.
      s1_row_q   <= ADDR_W'(pixel_in.vcount) * WidthA;
      s1_col_q   <= ADDR_W'(pixel_in.hcount);
      s1_color_q <= pixel_in.color;
      s2_valid_q <= s1_valid_q;
      s2_addr_q  <= s1_row_q + s1_col_q;
      s2_color_q <= s1_color_q;
    end
  end

  assign s1_valid = s1_valid_q;
  assign wr_valid = s2_valid_q;
  assign wr_addr  = s2_addr_q;
  assign wr_data  = s2_color_q;

endmodule

// File: rtl/framebuffer_writer.sv
// Pixel-stream sink: clips rasterizer pixels, writes them to the framebuffer BRAM and performs
// whole-frame clears on request.
// Optional feature macro: DOUBLE_BUFFER_EN (two banks, bank swap via swap_in).
// Ports:
//   clk_in, rst_in         : clock, synchronous active-low reset
//   hcount_in, vcount_in   : pixel coordinates
//   pixel_valid_in         : pixel offered this cycle
//   color_in               : pixel colour
//   ready_out              : pixels accepted this cycle
//   clear_in               : pulse, fill frame with clear_color_in
//   clear_color_in         : fill colour
//   busy_out               : draining or clearing
//   bram_addr_out/data/we  : BRAM write port (addr MSB = write bank with DOUBLE_BUFFER_EN)
//   dropped_count_out      : saturating count of lost pixels
//   bank_sel_out           : display bank
//   swap_in                : bank swap request
module framebuffer_writer
  import rendering_pkg::*;
#(
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned HEIGHT  = DefHeight,
  parameter int unsigned COLOR_W = DefColorW,
  parameter int unsigned ADDR_W  = $clog2(WIDTH * HEIGHT)
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [10:0]        hcount_in,
  input  logic [9:0]         vcount_in,
  input  logic               pixel_valid_in,
  input  logic [COLOR_W-1:0] color_in,
  output logic               ready_out,
  input  logic               clear_in,
  input  logic [COLOR_W-1:0] clear_color_in,
  output logic               busy_out,
`ifdef DOUBLE_BUFFER_EN
  output logic [ADDR_W:0]    bram_addr_out,
`else
  output logic [ADDR_W-1:0]  bram_addr_out,
`endif
  output logic [COLOR_W-1:0] bram_data_out,
  output logic               bram_we_out,
  output logic [15:0]        dropped_count_out,
  output logic               bank_sel_out,
  input  logic               swap_in
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(WIDTH * HEIGHT - 1);

  fb_state_t            state_q, state_d;
  logic [ADDR_W-1:0]    clr_addr_q, clr_addr_d;
  logic [COLOR_W-1:0]   clr_color_q, clr_color_d;
  logic [15:0]          drop_q;
  logic                 take, clipped, s1_valid, wr_valid;
  logic [ADDR_W-1:0]    wr_addr, lin_addr;
  logic [DefColorW-1:0] wr_data;
  logic                 swap_req, swap_pend_q, do_swap, bank_q;
  pixel_t               pixel;

  assign pixel = '{hcount: hcount_in, vcount: vcount_in, color: color_in};

`ifdef DOUBLE_BUFFER_EN
  assign swap_req = swap_in || swap_pend_q;
  // A swap requested together with a clear is carried into DRAIN so it lands before the sweep.
  assign do_swap  = !s1_valid && (((state_q == DRAW) && swap_req) ||
                                  ((state_q == DRAIN) && swap_pend_q));
`else
  logic unused_swap;
  assign unused_swap = swap_in;
  assign swap_req    = 1'b0;
  assign do_swap     = 1'b0;
`endif

  assign ready_out = (state_q == DRAW) && !swap_req;
  assign busy_out  = (state_q == DRAIN) || (state_q == CLEAR);
  assign take      = pixel_valid_in && ready_out;

  fb_addr_gen #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .take_in  (take),
    .pixel_in (pixel),
    .clipped  (clipped),
    .s1_valid (s1_valid),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    clr_color_d = clr_color_q;
    unique case (state_q)
      DRAW: begin
        if (clear_in) begin
          clr_color_d = clear_color_in;
          clr_addr_d  = '0;
          // Stage 2 retires this cycle, so only newer pixels require a drain.
          state_d     = (take || s1_valid) ? DRAIN : CLEAR;
        end
      end
      DRAIN: begin
        if (!s1_valid) state_d = CLEAR;
      end
      CLEAR: begin
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == LastAddr) begin
          clr_addr_d = '0;
          state_d    = DRAW;
        end
      end
      default: state_d = DRAW;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q     <= DRAW;
      clr_addr_q  <= '0;
      clr_color_q <= '0;
      drop_q      <= '0;
      swap_pend_q <= 1'b0;
      bank_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      clr_color_q <= clr_color_d;
      if (((pixel_valid_in && !ready_out) || (take && clipped)) && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 16'd1;
      end
      swap_pend_q <= swap_req && !do_swap;
      if (do_swap) bank_q <= !bank_q;
    end
  end

  always_comb begin
    bram_we_out   = wr_valid || (state_q == CLEAR);
    lin_addr      = (state_q == CLEAR) ? clr_addr_q : wr_addr;
    bram_data_out = (state_q == CLEAR) ? clr_color_q : COLOR_W'(wr_data);
  end

`ifdef DOUBLE_BUFFER_EN
  assign bram_addr_out = {!bank_q, lin_addr};
`else
  assign bram_addr_out = lin_addr;
`endif

  assign bank_sel_out      = bank_q;
  assign dropped_count_out = drop_q;

endmodule

// File: tb/tb_framebuffer_writer.sv
module tb_framebuffer_writer;
  import rendering_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [10:0] hcount_in = '0;
  logic [9:0]  vcount_in = '0;
  logic        pixel_valid_in = 1'b0;
  logic [7:0]  color_in = '0;
  logic        clear_in = 1'b0;
  logic [7:0]  clear_color_in = '0;
  logic        swap_in = 1'b0;
  logic        ready_out, busy_out, bram_we_out, bank_sel_out;
`ifdef DOUBLE_BUFFER_EN
  logic [16:0] bram_addr_out;
`else
  logic [15:0] bram_addr_out;
`endif
  logic [7:0]  bram_data_out;
  logic [15:0] dropped_count_out;

  int total = 0;
  int bad = 0;
  int exp_drop = 0;

  always #5 clk_in = ~clk_in;

  framebuffer_writer dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .hcount_in         (hcount_in),
    .vcount_in         (vcount_in),
    .pixel_valid_in    (pixel_valid_in),
    .color_in          (color_in),
    .ready_out         (ready_out),
    .clear_in          (clear_in),
    .clear_color_in    (clear_color_in),
    .busy_out          (busy_out),
    .bram_addr_out     (bram_addr_out),
    .bram_data_out     (bram_data_out),
    .bram_we_out       (bram_we_out),
    .dropped_count_out (dropped_count_out),
    .bank_sel_out      (bank_sel_out),
    .swap_in           (swap_in)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input int h, input int v, input logic [7:0] c, input logic vld);
    hcount_in      = 11'(h);
    vcount_in      = 10'(v);
    color_in       = c;
    pixel_valid_in = vld;
  endtask

  initial begin
    int first_bad;
    logic [31:0] bad_addr;

    // Reset state
    tick();
    tick();
    check("rst_ready", 32'(ready_out), 1);
    check("rst_busy", 32'(busy_out), 0);
    check("rst_we", 32'(bram_we_out), 0);
    check("rst_addr", 32'(bram_addr_out), 0);
    check("rst_data", 32'(bram_data_out), 0);
    check("rst_drop", 32'(dropped_count_out), 0);
    check("rst_bank", 32'(bank_sel_out), 0);
    rst_in = 1'b1;
    tick();

    // Single pixel: written two cycles after acceptance
    drive(10, 2, 8'h5A, 1'b1);
    tick();
    drive(0, 0, 8'h00, 1'b0);
    check("p1_we_early", 32'(bram_we_out), 0);
    tick();
    check("p1_we", 32'(bram_we_out), 1);
    check("p1_addr", 32'(bram_addr_out[15:0]), 650);
    check("p1_data", 32'(bram_data_out), 32'h5A);
    tick();
    check("p1_we_after", 32'(bram_we_out), 0);

    // Last in-frame pixel followed by an hcount-clipped one
    drive(319, 179, 8'h3C, 1'b1);
    tick();
    drive(320, 0, 8'h99, 1'b1);
    tick();
    drive(0, 0, 8'h00, 1'b0);
    exp_drop = 1;
    check("edge_we", 32'(bram_we_out), 1);
    check("edge_addr", 32'(bram_addr_out[15:0]), 57599);
    check("edge_data", 32'(bram_data_out), 32'h3C);
    check("edge_drop", 32'(dropped_count_out), 32'(exp_drop));
    tick();
    check("clip_h_no_we", 32'(bram_we_out), 0);

    // vcount clip
    drive(0, 180, 8'h44, 1'b1);
    tick();
    drive(0, 0, 8'h00, 1'b0);
    exp_drop = 2;
    tick();
    check("clip_v_no_we", 32'(bram_we_out), 0);
    check("clip_v_drop", 32'(dropped_count_out), 32'(exp_drop));

    // Clear with two pixels in flight
    drive(5, 0, 8'h11, 1'b1);
    tick();
    drive(6, 0, 8'h22, 1'b1);
    tick();
    drive(0, 0, 8'h00, 1'b0);
    clear_in       = 1'b1;
    clear_color_in = 8'h00;
    check("fl_a_addr", 32'(bram_addr_out[15:0]), 5);
    check("fl_a_data", 32'(bram_data_out), 32'h11);
    tick();
    clear_in = 1'b0;
    check("fl_b_we", 32'(bram_we_out), 1);
    check("fl_b_addr", 32'(bram_addr_out[15:0]), 6);
    check("fl_b_data", 32'(bram_data_out), 32'h22);
    check("drain_busy", 32'(busy_out), 1);
    check("drain_ready", 32'(ready_out), 0);
    tick();
    first_bad = -1;
    bad_addr  = '0;
    for (int i = 0; i < 57600; i++) begin
      if (i == 100) drive(1, 1, 8'hFF, 1'b1);
      if (i == 110) drive(0, 0, 8'h00, 1'b0);
      if ((first_bad < 0) && !((bram_we_out === 1'b1) && (32'(bram_addr_out[15:0]) === 32'(i)) &&
          (bram_data_out === 8'h00) && (busy_out === 1'b1) && (ready_out === 1'b0))) begin
        first_bad = i;
        bad_addr  = 32'(bram_addr_out);
      end
      tick();
    end
    exp_drop = 12;
    check("sweep_first_bad_idx", 32'(first_bad), 32'hFFFF_FFFF);
    check("sweep_bad_addr", bad_addr, 0);
    check("post_clear_ready", 32'(ready_out), 1);
    check("post_clear_busy", 32'(busy_out), 0);
    check("post_clear_we", 32'(bram_we_out), 0);
    check("stall_drop", 32'(dropped_count_out), 32'(exp_drop));

    // Clear from an empty pipeline goes straight to the sweep; reset aborts it
    clear_in       = 1'b1;
    clear_color_in = 8'h77;
    tick();
    clear_in = 1'b0;
    check("clr2_busy", 32'(busy_out), 1);
    check("clr2_we", 32'(bram_we_out), 1);
    check("clr2_addr0", 32'(bram_addr_out[15:0]), 0);
    check("clr2_data", 32'(bram_data_out), 32'h77);
    for (int n = 0; n < 2000 && bram_addr_out[15:0] != 16'd1000; n++) tick();
    check("clr2_reach_1000", 32'(bram_addr_out[15:0]), 1000);
    rst_in = 1'b0;
    tick();
    check("abort_we", 32'(bram_we_out), 0);
    check("abort_busy", 32'(busy_out), 0);
    check("abort_ready", 32'(ready_out), 1);
    check("abort_drop", 32'(dropped_count_out), 0);
    rst_in = 1'b1;
    tick();
    check("abort_we_after", 32'(bram_we_out), 0);

`ifdef DOUBLE_BUFFER_EN
    swap_in = 1'b1;
    check("swap_stall", 32'(ready_out), 0);
    tick();
    swap_in = 1'b0;
    check("swap_bank", 32'(bank_sel_out), 1);
    check("swap_ready", 32'(ready_out), 1);
    drive(0, 0, 8'hAB, 1'b1);
    tick();
    drive(0, 0, 8'h00, 1'b0);
    tick();
    check("db_pix_we", 32'(bram_we_out), 1);
    check("db_pix_addr", 32'(bram_addr_out), 0);
    check("db_pix_data", 32'(bram_data_out), 32'hAB);
    swap_in        = 1'b1;
    clear_in       = 1'b1;
    clear_color_in = 8'hCD;
    tick();
    swap_in  = 1'b0;
    clear_in = 1'b0;
    check("db_sc_bank", 32'(bank_sel_out), 0);
    check("db_sc_busy", 32'(busy_out), 1);
    check("db_sc_addr0", 32'(bram_addr_out), 32'h1_0000);
    check("db_sc_data", 32'(bram_data_out), 32'hCD);
    tick();
    check("db_sc_addr1", 32'(bram_addr_out), 32'h1_0001);
    rst_in = 1'b0;
    tick();
    rst_in = 1'b1;
    check("db_rst_bank", 32'(bank_sel_out), 0);
`else
    swap_in = 1'b1;
    tick();
    swap_in = 1'b0;
    check("sb_swap_ignored_bank", 32'(bank_sel_out), 0);
    check("sb_swap_ignored_ready", 32'(ready_out), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
